// File: rtl/nes_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : nes_mem_arbiter
// Description : Arbiter for the shared 22-bit game memory. PRG lives at
//               0x000000 and CHR at 0x200000. Three requesters share one
//               memory-controller port: the loader (writes), the CPU
//               (reads/writes) and the PPU (reads). Each strobe is captured
//               into a per-requester pending slot. One memory transaction
//               runs at a time. Grant order is LD > PPU > CPU, except that
//               the CPU overtakes the PPU once it has been passed over twice.
// Ports       : clk/reset       - clock, asynchronous active-low reset
//               ld_*            - loader write strobe/address/data, ld_done
//               cpu_*           - CPU strobe, we/addr/wdata in; ack/rdata out
//               ppu_*           - PPU strobe, addr in; ack/rdata out
//               ram_*           - memory-controller request/response
//               overrun, busy   - sticky dropped-strobe flag, BUSY indicator
// Revision    : 1.0 - initial release
// ============================================================================
module nes_mem_arbiter #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_write,
    input  logic              ld_done,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ppu_req,
    input  logic [ADDR_W-1:0] ppu_addr,
    output logic              ppu_ack,
    output logic [DATA_W-1:0] ppu_rdata,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ack,
    output logic              overrun,
    output logic              busy
);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;
    typedef enum logic [1:0] {SRC_LD = 2'd0, SRC_CPU = 2'd1, SRC_PPU = 2'd2} src_t;

    state_t            state_q, state_d;
    src_t              winner_q, winner_d;
    logic [1:0]        skip_q, skip_d;
    logic              ld_pend_q, ld_pend_d;
    logic              cpu_pend_q, cpu_pend_d;
    logic              ppu_pend_q, ppu_pend_d;
    logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
    logic [ADDR_W-1:0] cpu_addr_q, cpu_addr_d;
    logic [ADDR_W-1:0] ppu_addr_q, ppu_addr_d;
    logic [DATA_W-1:0] ld_data_q, ld_data_d;
    logic [DATA_W-1:0] cpu_wdata_q, cpu_wdata_d;
    logic              cpu_we_q, cpu_we_d;
    logic              ram_req_q, ram_req_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              ppu_ack_q, ppu_ack_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] ppu_rdata_q, ppu_rdata_d;
    logic              overrun_q, overrun_d;
    logic              ld_clr, cpu_clr, ppu_clr;
    logic              cpu_elig, ppu_elig, cpu_first;

    always_comb begin
        state_d     = state_q;
        winner_d    = winner_q;
        skip_d      = skip_q;
        ram_req_d   = ram_req_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        cpu_ack_d   = 1'b0;
        ppu_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        ppu_rdata_d = ppu_rdata_q;
        ld_clr      = 1'b0;
        cpu_clr     = 1'b0;
        ppu_clr     = 1'b0;

        // CPU and PPU are held off until the game image is fully loaded.
        cpu_elig  = cpu_pend_q & ld_done;
        ppu_elig  = ppu_pend_q & ld_done;
        // A counter that saturated at 3 through loader grants still favours
        // the CPU, so loader traffic cannot re-starve it.
        cpu_first = cpu_elig & (~ppu_elig | (skip_q >= 2'd2));

        case (state_q)
            ST_IDLE: begin
                if (ld_pend_q | cpu_elig | ppu_elig) begin
                    state_d   = ST_BUSY;
                    ram_req_d = 1'b1;
                    if (ld_pend_q) begin
                        winner_d    = SRC_LD;
                        ram_we_d    = 1'b1;
                        ram_addr_d  = ld_addr_q;
                        ram_wdata_d = ld_data_q;
                    end else if (cpu_first) begin
                        winner_d    = SRC_CPU;
                        ram_we_d    = cpu_we_q;
                        ram_addr_d  = cpu_addr_q;
                        ram_wdata_d = cpu_wdata_q;
                    end else begin
                        winner_d    = SRC_PPU;
                        ram_we_d    = 1'b0;
                        ram_addr_d  = ppu_addr_q;
                        ram_wdata_d = '0;
                    end
                    if (!ld_pend_q && cpu_first) begin
                        skip_d = 2'd0;
                    end else if (cpu_elig && (skip_q != 2'd3)) begin
                        skip_d = skip_q + 2'd1;
                    end
                end
            end
            ST_BUSY: begin
                if (ram_ack) begin
                    state_d   = ST_IDLE;
                    ram_req_d = 1'b0;
                    case (winner_q)
                        SRC_LD: ld_clr = 1'b1;
                        SRC_CPU: begin
                            cpu_clr   = 1'b1;
                            cpu_ack_d = 1'b1;
                            if (!cpu_we_q) begin
                                cpu_rdata_d = ram_rdata;
                            end
                        end
                        default: begin
                            ppu_clr     = 1'b1;
                            ppu_ack_d   = 1'b1;
                            ppu_rdata_d = ram_rdata;
                        end
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Capture: completion clears the slot first, so a strobe arriving in
        // the completion cycle is accepted rather than counted as an overrun.
        ld_pend_d   = ld_pend_q & ~ld_clr;
        cpu_pend_d  = cpu_pend_q & ~cpu_clr;
        ppu_pend_d  = ppu_pend_q & ~ppu_clr;
        ld_addr_d   = ld_addr_q;
        ld_data_d   = ld_data_q;
        cpu_addr_d  = cpu_addr_q;
        cpu_wdata_d = cpu_wdata_q;
        cpu_we_d    = cpu_we_q;
        ppu_addr_d  = ppu_addr_q;
        overrun_d   = overrun_q;

        if (ld_write) begin
            if (ld_pend_d) begin
                overrun_d = 1'b1;
            end else begin
                ld_pend_d = 1'b1;
                ld_addr_d = ld_addr;
                ld_data_d = ld_data;
            end
        end
        if (cpu_req) begin
            if (cpu_pend_d) begin
                overrun_d = 1'b1;
            end else begin
                cpu_pend_d  = 1'b1;
                cpu_addr_d  = cpu_addr;
                cpu_wdata_d = cpu_wdata;
                cpu_we_d    = cpu_we;
            end
        end
        if (ppu_req) begin
            if (ppu_pend_d) begin
                overrun_d = 1'b1;
            end else begin
                ppu_pend_d = 1'b1;
                ppu_addr_d = ppu_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            winner_q    <= SRC_LD;
            skip_q      <= 2'd0;
            ld_pend_q   <= 1'b0;
            cpu_pend_q  <= 1'b0;
            ppu_pend_q  <= 1'b0;
            ld_addr_q   <= '0;
            ld_data_q   <= '0;
            cpu_addr_q  <= '0;
            cpu_wdata_q <= '0;
            cpu_we_q    <= 1'b0;
            ppu_addr_q  <= '0;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            ppu_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            ppu_rdata_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            skip_q      <= skip_d;
            ld_pend_q   <= ld_pend_d;
            cpu_pend_q  <= cpu_pend_d;
            ppu_pend_q  <= ppu_pend_d;
            ld_addr_q   <= ld_addr_d;
            ld_data_q   <= ld_data_d;
            cpu_addr_q  <= cpu_addr_d;
            cpu_wdata_q <= cpu_wdata_d;
            cpu_we_q    <= cpu_we_d;
            ppu_addr_q  <= ppu_addr_d;
            ram_req_q   <= ram_req_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            cpu_ack_q   <= cpu_ack_d;
            ppu_ack_q   <= ppu_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            ppu_rdata_q <= ppu_rdata_d;
            overrun_q   <= overrun_d;
        end
    end

    assign ram_req   = ram_req_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign ppu_ack   = ppu_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign ppu_rdata = ppu_rdata_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q == ST_BUSY);

endmodule
`default_nettype wire

// File: tb/tb_nes_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_nes_mem_arbiter
// Description : Self-checking bench for nes_mem_arbiter. It contains a
//               memory-controller responder with configurable latency and a
//               transaction-level reference model of the arbitration rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nes_mem_arbiter;
    logic        clk = 1'b0, reset = 1'b0;
    logic [21:0] ld_addr = '0, cpu_addr = '0, ppu_addr = '0;
    logic [7:0]  ld_data = '0, cpu_wdata = '0, ram_rdata = '0;
    logic        ld_write = 0, ld_done = 0, cpu_req = 0, cpu_we = 0, ppu_req = 0, ram_ack = 0;
    logic        cpu_ack, ppu_ack, ram_req, ram_we, overrun, busy;
    logic [7:0]  cpu_rdata, ppu_rdata, ram_wdata;
    logic [21:0] ram_addr;

    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    nes_mem_arbiter #(.ADDR_W(22), .DATA_W(8)) dut (
        .clk(clk), .reset(reset),
        .ld_addr(ld_addr), .ld_data(ld_data), .ld_write(ld_write), .ld_done(ld_done),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ppu_req(ppu_req), .ppu_addr(ppu_addr), .ppu_ack(ppu_ack), .ppu_rdata(ppu_rdata),
        .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_ack(ram_ack), .overrun(overrun), .busy(busy)
    );

    // ---------------- memory controller responder ----------------
    logic [7:0] mem [int];
    int mem_lat = 1;
    int mem_cnt = 0;

    function automatic logic [7:0] mem_rd(input logic [21:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Advance to the next falling edge, drop one-cycle strobes and let the
    // memory controller answer a held request after mem_lat cycles.
    task automatic tick();
        @(negedge clk);
        ld_write = 0; cpu_req = 0; ppu_req = 0;
        if (ram_ack) begin
            ram_ack = 0; mem_cnt = 0;
        end else if (ram_req && reset) begin
            mem_cnt++;
            if (mem_cnt >= mem_lat) begin
                ram_ack = 1;
                if (ram_we) mem[int'(ram_addr)] = ram_wdata;
                else ram_rdata = mem_rd(ram_addr);
            end
        end
    endtask

    // ---------------- reference model ----------------
    // Requester index: 0 = loader, 1 = CPU, 2 = PPU.
    bit          m_pend [3];
    logic [21:0] m_addr [3];
    logic [7:0]  m_data [3];
    bit          m_we   [3];
    bit          m_busy;
    int          m_win, m_skip;
    bit          e_req, e_we, e_cack, e_pack, e_ovr;
    logic [21:0] e_addr;
    logic [7:0]  e_wdata, e_crd, e_prd;

    always @(posedge clk or negedge reset) begin : ref_model
        int          done;
        int          order [3];
        bit          stb [3];
        logic [21:0] sa  [3];
        logic [7:0]  sd  [3];
        bit          sw  [3];
        if (!reset) begin
            for (int r = 0; r < 3; r++) begin
                m_pend[r] = 0; m_addr[r] = '0; m_data[r] = '0; m_we[r] = 0;
            end
            m_busy = 0; m_win = -1; m_skip = 0;
            e_req = 0; e_we = 0; e_addr = '0; e_wdata = '0;
            e_cack = 0; e_pack = 0; e_crd = '0; e_prd = '0; e_ovr = 0;
        end else begin
            done = -1;
            e_cack = 0; e_pack = 0;
            if (m_busy) begin
                if (ram_ack) begin
                    done = m_win; m_busy = 0; e_req = 0;
                    if (m_win == 1) begin
                        e_cack = 1;
                        if (!m_we[1]) e_crd = ram_rdata;
                    end
                    if (m_win == 2) begin
                        e_pack = 1; e_prd = ram_rdata;
                    end
                end
            end else begin
                if (m_skip >= 2) begin order[0] = 0; order[1] = 1; order[2] = 2; end
                else             begin order[0] = 0; order[1] = 2; order[2] = 1; end
                m_win = -1;
                for (int i = 0; i < 3; i++)
                    if (m_win < 0 && m_pend[order[i]] && (order[i] == 0 || ld_done))
                        m_win = order[i];
                if (m_win >= 0) begin
                    m_busy = 1; e_req = 1;
                    e_we = m_we[m_win]; e_addr = m_addr[m_win]; e_wdata = m_data[m_win];
                    if (m_win == 1) m_skip = 0;
                    else if (m_pend[1] && ld_done) m_skip = (m_skip < 3) ? m_skip + 1 : 3;
                end
            end
            if (done >= 0) m_pend[done] = 0;
            stb[0] = ld_write; sa[0] = ld_addr;  sd[0] = ld_data;   sw[0] = 1'b1;
            stb[1] = cpu_req;  sa[1] = cpu_addr; sd[1] = cpu_wdata; sw[1] = cpu_we;
            stb[2] = ppu_req;  sa[2] = ppu_addr; sd[2] = 8'h00;     sw[2] = 1'b0;
            for (int r = 0; r < 3; r++) begin
                if (stb[r]) begin
                    if (m_pend[r]) e_ovr = 1;
                    else begin
                        m_pend[r] = 1; m_addr[r] = sa[r]; m_data[r] = sd[r]; m_we[r] = sw[r];
                    end
                end
            end
        end
    end

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        @(negedge clk);
        reset = 0; ram_ack = 0; mem_cnt = 0;
        #1;
        vectors++; if (ram_req !== 1'b0)   begin miscompares++; $display("FAIL reset ram_req got %0h want 0", ram_req); end
        vectors++; if (ram_we !== 1'b0)    begin miscompares++; $display("FAIL reset ram_we got %0h want 0", ram_we); end
        vectors++; if (ram_addr !== 22'h0) begin miscompares++; $display("FAIL reset ram_addr got %0h want 0", ram_addr); end
        vectors++; if (ram_wdata !== 8'h0) begin miscompares++; $display("FAIL reset ram_wdata got %0h want 0", ram_wdata); end
        vectors++; if (cpu_ack !== 1'b0)   begin miscompares++; $display("FAIL reset cpu_ack got %0h want 0", cpu_ack); end
        vectors++; if (ppu_ack !== 1'b0)   begin miscompares++; $display("FAIL reset ppu_ack got %0h want 0", ppu_ack); end
        vectors++; if (cpu_rdata !== 8'h0) begin miscompares++; $display("FAIL reset cpu_rdata got %0h want 0", cpu_rdata); end
        vectors++; if (ppu_rdata !== 8'h0) begin miscompares++; $display("FAIL reset ppu_rdata got %0h want 0", ppu_rdata); end
        vectors++; if (overrun !== 1'b0)   begin miscompares++; $display("FAIL reset overrun got %0h want 0", overrun); end
        vectors++; if (busy !== 1'b0)      begin miscompares++; $display("FAIL reset busy got %0h want 0", busy); end
        repeat (2) @(negedge clk);
        reset = 1;
    endtask

    task automatic test_loader_write();
        bit any_ack = 0;
        mem_lat = 3;
        ld_addr = 22'h000005; ld_data = 8'hA9; ld_write = 1;
        tick();
        vectors++; if (ram_req !== 1'b0) begin miscompares++; $display("FAIL ld_req_early got %0h want 0", ram_req); end
        tick();
        vectors++; if (ram_req !== 1'b1)       begin miscompares++; $display("FAIL ld_req got %0h want 1", ram_req); end
        vectors++; if (ram_we !== 1'b1)        begin miscompares++; $display("FAIL ld_we got %0h want 1", ram_we); end
        vectors++; if (ram_addr !== 22'h000005) begin miscompares++; $display("FAIL ld_addr got %0h want 5", ram_addr); end
        vectors++; if (ram_wdata !== 8'hA9)    begin miscompares++; $display("FAIL ld_wdata got %0h want a9", ram_wdata); end
        vectors++; if (busy !== 1'b1)          begin miscompares++; $display("FAIL ld_busy got %0h want 1", busy); end
        repeat (8) begin
            tick();
            if (cpu_ack || ppu_ack) any_ack = 1;
        end
        vectors++; if (any_ack !== 1'b0) begin miscompares++; $display("FAIL ld_noack got %0h want 0", any_ack); end
        vectors++; if (ram_req !== 1'b0) begin miscompares++; $display("FAIL ld_done_req got %0h want 0", ram_req); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL ld_overrun got %0h want 0", overrun); end
        vectors++; if (mem[22'h5] !== 8'hA9) begin miscompares++; $display("FAIL ld_memwrite got %0h want a9", mem[22'h5]); end
    endtask

    task automatic test_cpu_read();
        int t;
        ld_done = 1; mem_lat = 1; mem[22'h100] = 8'h4C;
        cpu_req = 1; cpu_we = 0; cpu_addr = 22'h000100;
        for (t = 0; t < 10; t++) begin tick(); if (ram_ack) break; end
        vectors++; if (t >= 10) begin miscompares++; $display("FAIL cpu_rd_timeout got %0d cycles want <10", t); end
        tick();
        vectors++; if (cpu_ack !== 1'b1)   begin miscompares++; $display("FAIL cpu_rd_ack got %0h want 1", cpu_ack); end
        vectors++; if (cpu_rdata !== 8'h4C) begin miscompares++; $display("FAIL cpu_rd_data got %0h want 4c", cpu_rdata); end
        vectors++; if (ppu_ack !== 1'b0)   begin miscompares++; $display("FAIL cpu_rd_ppuack got %0h want 0", ppu_ack); end
        tick();
        vectors++; if (cpu_ack !== 1'b0)   begin miscompares++; $display("FAIL cpu_rd_pulse got %0h want 0", cpu_ack); end
        vectors++; if (cpu_rdata !== 8'h4C) begin miscompares++; $display("FAIL cpu_rd_hold got %0h want 4c", cpu_rdata); end
    endtask

    task automatic test_skip();
        int  grants [$];
        int  exp1 [4] = '{2, 2, 1, 2};
        int  exp2 [2] = '{2, 1};
        int  nppu = 1;
        bit  prev = 0;
        ld_done = 1; mem_lat = 1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 22'h000040; ppu_req = 1; ppu_addr = 22'h200010;
        for (int c = 0; c < 40 && grants.size() < 4; c++) begin
            tick();
            if (ram_req && !prev) grants.push_back(ram_addr[21] ? 2 : 1);
            prev = ram_req;
            if (ram_ack && ram_addr[21] && nppu < 3) begin
                ppu_req = 1; ppu_addr = 22'h200010 + 22'(nppu); nppu++;
            end
        end
        repeat (4) tick();
        vectors++; if (grants.size() != 4) begin miscompares++; $display("FAIL skip_count got %0d want 4", grants.size()); end
        for (int i = 0; i < 4 && i < grants.size(); i++) begin
            vectors++;
            if (grants[i] != exp1[i]) begin miscompares++; $display("FAIL skip_grant%0d got %0d want %0d", i, grants[i], exp1[i]); end
        end
        grants.delete(); prev = 0;
        cpu_req = 1; cpu_addr = 22'h000040; ppu_req = 1; ppu_addr = 22'h200030;
        for (int c = 0; c < 20 && grants.size() < 2; c++) begin
            tick();
            if (ram_req && !prev) grants.push_back(ram_addr[21] ? 2 : 1);
            prev = ram_req;
        end
        repeat (4) tick();
        vectors++; if (grants.size() != 2) begin miscompares++; $display("FAIL skip_clear_count got %0d want 2", grants.size()); end
        for (int i = 0; i < 2 && i < grants.size(); i++) begin
            vectors++;
            if (grants[i] != exp2[i]) begin miscompares++; $display("FAIL skip_clear_grant%0d got %0d want %0d", i, grants[i], exp2[i]); end
        end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL skip_overrun got %0h want 0", overrun); end
    endtask

    task automatic test_ld_done_gate();
        int n_ld = 0, n_cpu = 0, t;
        bit prev = 0;
        ld_done = 0; mem_lat = 2;
        cpu_req = 1; cpu_we = 1; cpu_addr = 22'h000007; cpu_wdata = 8'h33;
        ld_write = 1; ld_addr = 22'h000010; ld_data = 8'h01;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (c == 5) begin ld_write = 1; ld_addr = 22'h000011; ld_data = 8'h02; end
            if (ram_req && !prev) begin
                if (ram_addr == 22'h000007) n_cpu++;
                else if (ram_we) n_ld++;
            end
            prev = ram_req;
        end
        vectors++; if (n_cpu != 0) begin miscompares++; $display("FAIL gate_cpu got %0d want 0", n_cpu); end
        vectors++; if (n_ld != 2)  begin miscompares++; $display("FAIL gate_ld got %0d want 2", n_ld); end
        ld_done = 1;
        for (t = 0; t < 10; t++) begin tick(); if (ram_req) break; end
        vectors++; if (ram_addr !== 22'h000007) begin miscompares++; $display("FAIL gate_addr got %0h want 7", ram_addr); end
        vectors++; if (ram_we !== 1'b1)         begin miscompares++; $display("FAIL gate_we got %0h want 1", ram_we); end
        vectors++; if (ram_wdata !== 8'h33)     begin miscompares++; $display("FAIL gate_wdata got %0h want 33", ram_wdata); end
        for (t = 0; t < 10; t++) begin tick(); if (cpu_ack) break; end
        vectors++; if (cpu_ack !== 1'b1) begin miscompares++; $display("FAIL gate_ack got %0h want 1", cpu_ack); end
        vectors++; if (cpu_rdata !== mem_rd(22'h000040)) begin miscompares++; $display("FAIL gate_rdata got %0h want %0h", cpu_rdata, mem_rd(22'h000040)); end
    endtask

    task automatic test_overrun();
        int n = 0;
        bit prev = 0;
        mem_lat = 3;
        ld_write = 1; ld_addr = 22'h000020; ld_data = 8'h11;
        tick();
        ld_write = 1; ld_addr = 22'h000021; ld_data = 8'h22;
        tick();
        vectors++; if (overrun !== 1'b1)        begin miscompares++; $display("FAIL ovr_set got %0h want 1", overrun); end
        vectors++; if (ram_addr !== 22'h000020) begin miscompares++; $display("FAIL ovr_addr got %0h want 20", ram_addr); end
        prev = ram_req;
        if (ram_req) n++;
        repeat (15) begin
            tick();
            if (ram_req && !prev) n++;
            prev = ram_req;
        end
        vectors++; if (n != 1) begin miscompares++; $display("FAIL ovr_grants got %0d want 1", n); end
        vectors++; if (mem.exists(int'(22'h21))) begin miscompares++; $display("FAIL ovr_dropped got written want absent"); end
        vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_sticky got %0h want 1", overrun); end
    endtask

    task automatic test_reset_mid();
        bit any_ack = 0;
        int t;
        mem_lat = 4; ld_done = 1;
        ppu_req = 1; ppu_addr = 22'h200100;
        tick(); tick();
        vectors++; if (ram_req !== 1'b1) begin miscompares++; $display("FAIL mid_req got %0h want 1", ram_req); end
        tick();
        #2; reset = 0; ram_ack = 0; mem_cnt = 0;
        #1;
        vectors++; if ({ram_req, ram_we, cpu_ack, ppu_ack, overrun, busy} !== 6'b0)
            begin miscompares++; $display("FAIL mid_flags got %b want 000000", {ram_req, ram_we, cpu_ack, ppu_ack, overrun, busy}); end
        vectors++; if ({ram_addr, ram_wdata, cpu_rdata, ppu_rdata} !== 46'b0)
            begin miscompares++; $display("FAIL mid_buses got %0h want 0", {ram_addr, ram_wdata, cpu_rdata, ppu_rdata}); end
        @(negedge clk); reset = 1;
        repeat (6) begin tick(); if (cpu_ack || ppu_ack || ram_req) any_ack = 1; end
        vectors++; if (any_ack !== 1'b0) begin miscompares++; $display("FAIL mid_noack got %0h want 0", any_ack); end
        mem_lat = 1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 22'h000100;
        for (t = 0; t < 10; t++) begin tick(); if (cpu_ack) break; end
        vectors++; if (cpu_rdata !== 8'h4C) begin miscompares++; $display("FAIL mid_after got %0h want 4c", cpu_rdata); end
    endtask

    task automatic test_random();
        test_reset();
        ld_done = 1;
        for (int blk = 0; blk < 4; blk++) begin
            mem_lat = $urandom_range(1, 3);
            for (int c = 0; c < 100; c++) begin
                if ($urandom_range(0, 3) == 0) begin
                    cpu_req = 1; cpu_we = $urandom_range(0, 1);
                    cpu_addr = 22'($urandom_range(0, 22'h1FFFFF)); cpu_wdata = 8'($urandom);
                end
                if ($urandom_range(0, 3) == 0) begin
                    ppu_req = 1; ppu_addr = 22'h200000 | 22'($urandom_range(0, 16'h1FFF));
                end
                tick();
                vectors++; if (ram_req !== e_req)   begin miscompares++; $display("FAIL rnd_req got %0h want %0h", ram_req, e_req); end
                vectors++; if (busy !== m_busy)     begin miscompares++; $display("FAIL rnd_busy got %0h want %0h", busy, m_busy); end
                vectors++; if (cpu_ack !== e_cack)  begin miscompares++; $display("FAIL rnd_cack got %0h want %0h", cpu_ack, e_cack); end
                vectors++; if (ppu_ack !== e_pack)  begin miscompares++; $display("FAIL rnd_pack got %0h want %0h", ppu_ack, e_pack); end
                vectors++; if (cpu_rdata !== e_crd) begin miscompares++; $display("FAIL rnd_crd got %0h want %0h", cpu_rdata, e_crd); end
                vectors++; if (ppu_rdata !== e_prd) begin miscompares++; $display("FAIL rnd_prd got %0h want %0h", ppu_rdata, e_prd); end
                vectors++; if (overrun !== e_ovr)   begin miscompares++; $display("FAIL rnd_ovr got %0h want %0h", overrun, e_ovr); end
                if (e_req) begin
                    vectors++; if (ram_addr !== e_addr) begin miscompares++; $display("FAIL rnd_addr got %0h want %0h", ram_addr, e_addr); end
                    vectors++; if (ram_we !== e_we)     begin miscompares++; $display("FAIL rnd_we got %0h want %0h", ram_we, e_we); end
                    if (e_we) begin
                        vectors++; if (ram_wdata !== e_wdata) begin miscompares++; $display("FAIL rnd_wdata got %0h want %0h", ram_wdata, e_wdata); end
                    end
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_loader_write();
        test_cpu_read();
        test_skip();
        test_ld_done_gate();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/nes_mem_arbiter.md
# nes_mem_arbiter

Arbiter and sequencer for the single shared 22-bit game memory (PRG at 0x000000, CHR at 0x200000). Three requesters share one memory-controller port: the game loader (write strobes while a game loads), the CPU (PRG read/write), and the PPU (CHR read). The block captures each requester's strobe, issues one memory transaction at a time with fixed priority plus a CPU anti-starvation rule, and returns per-requester acknowledge pulses with read data.

## Interface
- ADDR_W, 22, memory address width
- DATA_W, 8, memory data width
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- ld_addr  in  ADDR_W  loader write address
- ld_data  in  DATA_W  loader write data
- ld_write  in  1  loader write strobe, one cycle per byte
- ld_done  in  1  loader finished; CPU/PPU ineligible while 0
- cpu_req  in  1  CPU request strobe, one cycle
- cpu_we  in  1  CPU write (1) / read (0), sampled with cpu_req
- cpu_addr  in  ADDR_W  CPU address, sampled with cpu_req
- cpu_wdata  in  DATA_W  CPU write data, sampled with cpu_req
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data, valid from cpu_ack until next cpu_ack
- ppu_req  in  1  PPU read strobe, one cycle
- ppu_addr  in  ADDR_W  PPU address, sampled with ppu_req
- ppu_ack  out  1  one-cycle completion pulse
- ppu_rdata  out  DATA_W  read data, valid from ppu_ack until next ppu_ack
- ram_req  out  1  transaction request, held until ram_ack
- ram_we  out  1  write transaction
- ram_addr  out  ADDR_W  transaction address
- ram_wdata  out  DATA_W  transaction write data
- ram_rdata  in  DATA_W  read data, valid in ram_ack cycle
- ram_ack  in  1  one-cycle completion from memory controller
- overrun  out  1  sticky: strobe arrived while same requester still pending
- busy  out  1  high in BUSY state

## Operation
- Per requester (LD, CPU, PPU): pending bit plus latched addr/data/we. Strobe sets pending and latches fields (LD: we=1; PPU: we=0).
- Strobe while that requester's pending bit stays set: strobe dropped, latched fields unchanged, overrun set (cleared only by reset).
- Strobe in same cycle its pending bit clears (completion): accepted as new pending, no overrun.
- States: IDLE, BUSY.
- IDLE: if any eligible pending, select winner, load ram_* from winner's latches, ram_req<=1, go BUSY. LD always eligible; CPU/PPU eligible only when ld_done=1.
- Priority: LD > PPU > CPU, except CPU beats PPU (never LD) when skip==2.
- skip: 2-bit saturating counter; +1 when CPU pending and eligible but LD or PPU granted; cleared when CPU granted.
- BUSY: ram_req/we/addr/wdata held stable. On ram_ack: ram_req<=0, clear winner's pending, winner's ack<=1 for one cycle, read data latched into cpu_rdata/ppu_rdata for reads, go IDLE.
- CPU write completion still pulses cpu_ack; cpu_rdata unchanged.
- ram_ack while IDLE: ignored.

## Timing
- Reset (reset=0): state IDLE; ram_req, ram_we, ram_addr, ram_wdata, cpu_ack, ppu_ack, cpu_rdata, ppu_rdata, overrun, busy all 0; pending bits and skip 0.
- Strobe at cycle N, block IDLE: pending at N+1, ram_req high from N+2.
- ram_ack at cycle M: ram_req low and requester ack high at M+1; next grant's ram_req earliest M+2 (one dead cycle).
- Minimum turnaround with 1-cycle memory: 3 cycles per transaction; loader byte rate must not exceed this (else overrun).
- Reset asserted mid-transaction: all pending work dropped, no ack issued; memory controller is reset by the same signal.
- ld_done falling while CPU/PPU pending: those stay pending, not granted until ld_done=1.

## Test plan
- Reset then ld_write at 0x000005 data 0xA9, ram_ack 2 cycles after ram_req -> ram_req high 2 cycles after strobe, ram_we=1, ram_addr=0x000005, ram_wdata=0xA9; no cpu_ack/ppu_ack; overrun=0.
- ld_done=1, cpu_req read 0x000100, ram_rdata=0x4C at ram_ack -> cpu_ack one cycle after ram_ack, cpu_rdata=0x4C held after pulse.
- cpu_req and ppu_req same cycle, PPU strobed again after each ppu_ack -> grants PPU, PPU, CPU (skip==2); skip returns to 0.
- ld_done=0, cpu_req and ld_write pending -> only loader transactions issue; raising ld_done -> CPU issued next.
- Two ld_write strobes 1 cycle apart while first in BUSY -> second dropped, overrun=1 and stays 1 until reset.
- reset pulled low during BUSY with ram_req=1 -> all outputs 0 immediately; after release no ack, new request served normally.
